// File: rtl/gpio_irq_ctrl.sv
// GPIO block with direction/data registers, synchronised and debounced inputs,
// and per-pin interrupt detection (edge or level) behind a simple register bus.
module gpio_irq_ctrl #(
  parameter int N_PINS      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        addr_i,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [N_PINS-1:0] gpio_in,
  output logic [N_PINS-1:0] gpio_out,
  output logic [N_PINS-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [5:0] ADDR_DIR      = 6'h00;
  localparam logic [5:0] ADDR_DOUT     = 6'h04;
  localparam logic [5:0] ADDR_DIN      = 6'h08;
  localparam logic [5:0] ADDR_DOUT_SET = 6'h0C;
  localparam logic [5:0] ADDR_DOUT_CLR = 6'h10;
  localparam logic [5:0] ADDR_DOUT_TGL = 6'h14;
  localparam logic [5:0] ADDR_IRQ_EN   = 6'h18;
  localparam logic [5:0] ADDR_IRQ_STAT = 6'h1C;
  localparam logic [5:0] ADDR_IRQ_TYPE = 6'h20;
  localparam logic [5:0] ADDR_IRQ_POL  = 6'h24;
  localparam logic [5:0] ADDR_IRQ_BOTH = 6'h28;
  localparam logic [5:0] ADDR_DB_CNT   = 6'h2C;

  logic [N_PINS-1:0] dir_q;
  logic [N_PINS-1:0] dout_q;
  logic [N_PINS-1:0] irq_en_q;
  logic [N_PINS-1:0] irq_stat_q;
  logic [N_PINS-1:0] irq_type_q;
  logic [N_PINS-1:0] irq_pol_q;
  logic [N_PINS-1:0] irq_both_q;
  logic [DB_W-1:0]   db_cnt_q;

  logic [N_PINS-1:0] sync_q [SYNC_STAGES];
  logic [N_PINS-1:0] sync_out;
  logic [N_PINS-1:0] db_val_q;
  logic [DB_W-1:0]   db_ctr_q [N_PINS];
  logic [N_PINS-1:0] filt;
  logic [N_PINS-1:0] filt_d_q;

  logic [N_PINS-1:0] wr_pins;
  logic [N_PINS-1:0] edge_rise;
  logic [N_PINS-1:0] edge_fall;
  logic [N_PINS-1:0] edge_evt;
  logic [N_PINS-1:0] level_evt;
  logic [N_PINS-1:0] stat_set;
  logic [N_PINS-1:0] stat_clr;
  logic [N_PINS-1:0] stat_next;
  logic [31:0]       rd_val;

  assign wr_pins  = wdata[N_PINS-1:0];
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign gpio_oe  = dir_q;
  assign gpio_out = dout_q;

  // Pad inputs are asynchronous, so every bit goes through a flop chain first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per-pin debounce: accept a new value only after it has been stable for
  // DB_CNT cycles; while debounce is off the held value just shadows the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_val_q <= '0;
      for (int i = 0; i < N_PINS; i++) db_ctr_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PINS; i++) begin
        if (db_cnt_q == '0) begin
          db_val_q[i] <= sync_out[i];
          db_ctr_q[i] <= '0;
        end else if (sync_out[i] != db_val_q[i]) begin
          if (db_ctr_q[i] + DB_W'(1) >= db_cnt_q) begin
            db_val_q[i] <= sync_out[i];
            db_ctr_q[i] <= '0;
          end else begin
            db_ctr_q[i] <= db_ctr_q[i] + DB_W'(1);
          end
        end else begin
          db_ctr_q[i] <= '0;
        end
      end
    end
  end

  // With debounce disabled the filtered value is the synchroniser output itself,
  // which keeps the input-to-status latency at SYNC_STAGES+1 edges.
  assign filt = (db_cnt_q == '0) ? sync_out : db_val_q;

  // Delayed copy of the filtered value for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) filt_d_q <= '0;
    else        filt_d_q <= filt;
  end

  // Event detection and the status update; a same-cycle set beats a clear.
  always_comb begin
    edge_rise = filt & ~filt_d_q;
    edge_fall = ~filt & filt_d_q;
    edge_evt  = (irq_both_q & (edge_rise | edge_fall)) |
                (~irq_both_q & ((irq_pol_q & edge_rise) | (~irq_pol_q & edge_fall)));
    level_evt = ~(filt ^ irq_pol_q);
    stat_set  = ((irq_type_q & level_evt) | (~irq_type_q & edge_evt)) & irq_en_q & ~dir_q;
    stat_clr  = '0;
    if (write_en && addr_i == ADDR_IRQ_STAT) stat_clr = wr_pins;
    stat_next = (irq_stat_q & ~stat_clr) | stat_set;
  end

  // Register writes, including the set/clear/toggle aliases of DOUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q      <= '0;
      dout_q     <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_type_q <= '0;
      irq_pol_q  <= '0;
      irq_both_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      irq_stat_q <= stat_next;
      if (write_en) begin
        case (addr_i)
          ADDR_DIR:      dir_q      <= wr_pins;
          ADDR_DOUT:     dout_q     <= wr_pins;
          ADDR_DOUT_SET: dout_q     <= dout_q | wr_pins;
          ADDR_DOUT_CLR: dout_q     <= dout_q & ~wr_pins;
          ADDR_DOUT_TGL: dout_q     <= dout_q ^ wr_pins;
          ADDR_IRQ_EN:   irq_en_q   <= wr_pins;
          ADDR_IRQ_TYPE: irq_type_q <= wr_pins;
          ADDR_IRQ_POL:  irq_pol_q  <= wr_pins;
          ADDR_IRQ_BOTH: irq_both_q <= wr_pins;
          ADDR_DB_CNT:   db_cnt_q   <= wdata[DB_W-1:0];
          default:       ;
        endcase
      end
    end
  end

  // Read mux over current register values; write-only and unmapped slots read 0.
  always_comb begin
    rd_val = '0;
    case (addr_i)
      ADDR_DIR:      rd_val[N_PINS-1:0] = dir_q;
      ADDR_DOUT:     rd_val[N_PINS-1:0] = dout_q;
      ADDR_DIN:      rd_val[N_PINS-1:0] = filt;
      ADDR_IRQ_EN:   rd_val[N_PINS-1:0] = irq_en_q;
      ADDR_IRQ_STAT: rd_val[N_PINS-1:0] = irq_stat_q;
      ADDR_IRQ_TYPE: rd_val[N_PINS-1:0] = irq_type_q;
      ADDR_IRQ_POL:  rd_val[N_PINS-1:0] = irq_pol_q;
      ADDR_IRQ_BOTH: rd_val[N_PINS-1:0] = irq_both_q;
      ADDR_DB_CNT:   rd_val[DB_W-1:0]   = db_cnt_q;
      default:       rd_val = '0;
    endcase
  end

  // Read data is captured on a read strobe, so a same-cycle write reads old data.
  always_ff @(posedge clk) begin
    if (!rst_n)       rdata <= '0;
    else if (read_en) rdata <= rd_val;
  end

  assign irq = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: a register-path vector table followed by
// hand-written interrupt, debounce, level, masking and reset sequences.
module tb_gpio_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  addr_i;
  logic        write_en;
  logic        read_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  int total;
  int bad;

  typedef struct {
    bit          is_read;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_out;
    logic [31:0] exp_oe;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [20];

  gpio_irq_ctrl #(.N_PINS(32), .SYNC_STAGES(2), .DB_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr_i   (addr_i),
    .write_en (write_en),
    .read_en  (read_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against the run never finishing.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    addr_i   = v.addr;
    wdata    = v.data;
    write_en = !v.is_read;
    read_en  = v.is_read;
    step();
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [31:0] d);
    addr_i   = a;
    wdata    = d;
    write_en = 1'b1;
    step();
    write_en = 1'b0;
  endtask

  task automatic read_reg(input logic [5:0] a, output logic [31:0] d);
    addr_i  = a;
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    d = rdata;
  endtask

  initial begin
    logic [31:0] rd;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    addr_i   = '0;
    write_en = 1'b0;
    read_en  = 1'b0;
    wdata    = '0;
    gpio_in  = '0;

    // Register path vectors: {is_read, addr, data, exp gpio_out, exp gpio_oe, exp rdata}
    vecs[0]  = '{1'b0, 6'h00, 32'h0000000F, 32'h00000000, 32'h0000000F, 32'h0};
    vecs[1]  = '{1'b0, 6'h04, 32'h00000005, 32'h00000005, 32'h0000000F, 32'h0};
    vecs[2]  = '{1'b0, 6'h0C, 32'h00000008, 32'h0000000D, 32'h0000000F, 32'h0};
    vecs[3]  = '{1'b0, 6'h10, 32'h00000001, 32'h0000000C, 32'h0000000F, 32'h0};
    vecs[4]  = '{1'b0, 6'h14, 32'h00000003, 32'h0000000F, 32'h0000000F, 32'h0};
    vecs[5]  = '{1'b1, 6'h04, 32'h0,        32'h0000000F, 32'h0000000F, 32'h0000000F};
    vecs[6]  = '{1'b1, 6'h00, 32'h0,        32'h0000000F, 32'h0000000F, 32'h0000000F};
    vecs[7]  = '{1'b1, 6'h0C, 32'h0,        32'h0000000F, 32'h0000000F, 32'h00000000};
    vecs[8]  = '{1'b1, 6'h08, 32'h0,        32'h0000000F, 32'h0000000F, 32'h00000000};
    vecs[9]  = '{1'b1, 6'h30, 32'h0,        32'h0000000F, 32'h0000000F, 32'h00000000};
    vecs[10] = '{1'b0, 6'h2C, 32'hFFFFFFF5, 32'h0000000F, 32'h0000000F, 32'h0};
    vecs[11] = '{1'b1, 6'h2C, 32'h0,        32'h0000000F, 32'h0000000F, 32'h00000005};
    vecs[12] = '{1'b0, 6'h24, 32'hA5A5A5A5, 32'h0000000F, 32'h0000000F, 32'h0};
    vecs[13] = '{1'b1, 6'h24, 32'h0,        32'h0000000F, 32'h0000000F, 32'hA5A5A5A5};
    vecs[14] = '{1'b0, 6'h04, 32'h12345678, 32'h12345678, 32'h0000000F, 32'h0};
    vecs[15] = '{1'b0, 6'h00, 32'h00000000, 32'h12345678, 32'h00000000, 32'h0};
    vecs[16] = '{1'b0, 6'h04, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0};
    vecs[17] = '{1'b0, 6'h2C, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0};
    vecs[18] = '{1'b1, 6'h2C, 32'h0,        32'h00000000, 32'h00000000, 32'h00000000};
    vecs[19] = '{1'b0, 6'h24, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0};

    // Reset state
    step();
    step();
    checkOutput("reset gpio_out", gpio_out, 32'h0);
    checkOutput("reset gpio_oe", gpio_oe, 32'h0);
    checkOutput("reset irq", {31'h0, irq}, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Register path table
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d gpio_out", i), gpio_out, vecs[i].exp_out);
      checkOutput($sformatf("vec%0d gpio_oe", i), gpio_oe, vecs[i].exp_oe);
      if (vecs[i].is_read) checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
    end

    // Read and write on the same address in one cycle returns the old value
    addr_i   = 6'h18;
    wdata    = 32'h00000055;
    write_en = 1'b1;
    read_en  = 1'b1;
    step();
    write_en = 1'b0;
    read_en  = 1'b0;
    checkOutput("rw same cycle old value", rdata, 32'h0);
    read_reg(6'h18, rd);
    checkOutput("rw same cycle new value", rd, 32'h00000055);
    write_reg(6'h18, 32'h0);

    // Rising edge interrupt on pin 8, no debounce
    write_reg(6'h24, 32'h00000100);
    write_reg(6'h18, 32'h00000100);
    step();
    gpio_in[8] = 1'b1;
    step();
    checkOutput("rise E0 irq", {31'h0, irq}, 32'h0);
    step();
    checkOutput("rise E1 irq", {31'h0, irq}, 32'h0);
    step();
    checkOutput("rise E2 irq", {31'h0, irq}, 32'h1);
    read_reg(6'h1C, rd);
    checkOutput("rise stat read", rd, 32'h00000100);
    write_reg(6'h1C, 32'h00000100);
    checkOutput("rise cleared irq", {31'h0, irq}, 32'h0);

    // Both-edge interrupt on pin 3 with a 4-cycle debounce
    write_reg(6'h18, 32'h00000008);
    write_reg(6'h28, 32'h00000008);
    write_reg(6'h2C, 32'h00000004);
    step();
    gpio_in[3] = 1'b1;
    step();
    step();
    step();
    gpio_in[3] = 1'b0;
    for (int k = 0; k < 10; k++) step();
    read_reg(6'h1C, rd);
    checkOutput("glitch no status", rd, 32'h0);
    checkOutput("glitch no irq", {31'h0, irq}, 32'h0);

    gpio_in[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 7) begin
        addr_i   = 6'h1C;
        wdata    = 32'h00000008;
        write_en = 1'b1;
      end
      step();
      write_en = 1'b0;
      checkOutput($sformatf("pulse rise k%0d irq", k), {31'h0, irq}, (k == 6) ? 32'h1 : 32'h0);
    end
    gpio_in[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput($sformatf("pulse fall k%0d irq", k), {31'h0, irq}, (k >= 6) ? 32'h1 : 32'h0);
    end

    // Level interrupt on pin 0, active low
    write_reg(6'h2C, 32'h0);
    write_reg(6'h28, 32'h0);
    write_reg(6'h24, 32'h0);
    write_reg(6'h20, 32'h00000001);
    write_reg(6'h18, 32'h00000001);
    step();
    step();
    write_reg(6'h1C, 32'hFFFFFFFF);
    read_reg(6'h1C, rd);
    checkOutput("level sticky stat", rd, 32'h00000001);
    checkOutput("level sticky irq", {31'h0, irq}, 32'h1);
    gpio_in[0] = 1'b1;
    step();
    step();
    step();
    write_reg(6'h1C, 32'h00000001);
    read_reg(6'h1C, rd);
    checkOutput("level released stat", rd, 32'h0);
    checkOutput("level released irq", {31'h0, irq}, 32'h0);

    // Output pins are masked from interrupts
    write_reg(6'h00, 32'h00000100);
    write_reg(6'h20, 32'h0);
    write_reg(6'h24, 32'h00000100);
    write_reg(6'h18, 32'h00000100);
    gpio_in[8] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    gpio_in[8] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    read_reg(6'h1C, rd);
    checkOutput("dir mask stat", rd, 32'h0);
    checkOutput("dir mask irq", {31'h0, irq}, 32'h0);

    // Reset with an interrupt pending
    write_reg(6'h18, 32'h00000101);
    write_reg(6'h20, 32'h00000001);
    write_reg(6'h24, 32'h00000101);
    write_reg(6'h04, 32'h0000ABCD);
    step();
    checkOutput("pre reset irq", {31'h0, irq}, 32'h1);
    read_reg(6'h00, rd);
    checkOutput("pre reset dir", rd, 32'h00000100);
    gpio_in = '0;
    rst_n   = 1'b0;
    step();
    rst_n   = 1'b1;
    checkOutput("post reset gpio_out", gpio_out, 32'h0);
    checkOutput("post reset gpio_oe", gpio_oe, 32'h0);
    checkOutput("post reset irq", {31'h0, irq}, 32'h0);
    checkOutput("post reset rdata", rdata, 32'h0);
    step();
    for (int a = 0; a <= 12; a++) begin
      read_reg(6'(a * 4), rd);
      checkOutput($sformatf("post reset read %02h", a * 4), rd, 32'h0);
    end
    checkOutput("post reset irq idle", {31'h0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
